// File: rtl/alu_arbiter.sv
// Round-robin arbiter that shares one 8-bit ALU between two requesters and runs
// each 16-bit request as two chained byte slices (low, then high) before acking.
module alu_arbiter #(
  parameter int         N_REQ  = 2,
  parameter logic [3:0] OP_ADD = 4'hA,
  parameter logic [3:0] OP_SUB = 4'hB,
  parameter logic [3:0] OP_AND = 4'hC,
  parameter logic [3:0] OP_OR  = 4'hD,
  parameter logic [3:0] OP_CMP = 4'hE
) (
  input  logic             IN_clk,
  input  logic             IN_reset,
  input  logic [N_REQ-1:0] IN_req,
  input  logic [3:0]       IN_op0,
  input  logic [15:0]      IN_a0,
  input  logic [15:0]      IN_b0,
  input  logic [3:0]       IN_op1,
  input  logic [15:0]      IN_a1,
  input  logic [15:0]      IN_b1,
  input  logic [7:0]       IN_S,
  input  logic             IN_carry_in,
  input  logic             IN_zero,
  output logic [7:0]       OUT_data_a,
  output logic [7:0]       OUT_data_b,
  output logic [3:0]       OUT_ALU_OP,
  output logic             OUT_carry_out,
  output logic [N_REQ-1:0] OUT_grant,
  output logic [N_REQ-1:0] OUT_ack,
  output logic [15:0]      OUT_result,
  output logic             OUT_carry,
  output logic             OUT_zero,
  output logic             OUT_neg_ans,
  output logic             OUT_less_than,
  output logic             OUT_busy
);

  // Handshake: a requester raises IN_req[i] with stable operands and holds it
  // until OUT_ack[i] pulses; it must drop IN_req[i] during the ack (DONE) cycle.
  typedef enum logic [1:0] {S_IDLE, S_LOW, S_HIGH, S_DONE} state_t;

  state_t      state_q, state_d;
  logic        last_grant_q;
  logic [3:0]  op_q;
  logic [15:0] a_q, b_q;
  logic [7:0]  res_lo_q;
  logic        z_lo_q, c_lo_q;
  logic        win;

  // On a tie the requester that did not win last time is chosen.
  assign win = (IN_req == 2'b11) ? ~last_grant_q : IN_req[1];

  always_ff @(posedge IN_clk) begin
    if (IN_reset) begin
      state_q       <= S_IDLE;
      last_grant_q  <= 1'b1;
      op_q          <= '0;
      a_q           <= '0;
      b_q           <= '0;
      res_lo_q      <= '0;
      z_lo_q        <= 1'b0;
      c_lo_q        <= 1'b0;
      OUT_grant     <= '0;
      OUT_ack       <= '0;
      OUT_result    <= '0;
      OUT_carry     <= 1'b0;
      OUT_zero      <= 1'b0;
      OUT_neg_ans   <= 1'b0;
      OUT_less_than <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        S_IDLE: begin
          if (|IN_req) begin
            op_q         <= win ? IN_op1 : IN_op0;
            a_q          <= win ? IN_a1  : IN_a0;
            b_q          <= win ? IN_b1  : IN_b0;
            OUT_grant    <= win ? 2'b10  : 2'b01;
            last_grant_q <= win;
          end
        end
        S_LOW: begin
          res_lo_q <= IN_S;
          z_lo_q   <= IN_zero;
          c_lo_q   <= IN_carry_in;
        end
        S_HIGH: begin
          OUT_result    <= {IN_S, res_lo_q};
          OUT_zero      <= z_lo_q & IN_zero;
          OUT_neg_ans   <= IN_S[7];
          OUT_carry     <= IN_carry_in;
          OUT_less_than <= (op_q == OP_CMP) & IN_carry_in;
          OUT_ack       <= OUT_grant;
        end
        default: begin
          OUT_ack   <= '0;
          OUT_grant <= '0;
        end
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (|IN_req) state_d = S_LOW;
      S_LOW:   state_d = S_HIGH;
      S_HIGH:  state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  // ALU drive decoded from state and the latched request; zero outside the slices.
  always_comb begin
    OUT_data_a    = '0;
    OUT_data_b    = '0;
    OUT_ALU_OP    = '0;
    OUT_carry_out = 1'b0;
    OUT_busy      = (state_q != S_IDLE);
    case (state_q)
      S_LOW: begin
        OUT_data_a    = a_q[7:0];
        OUT_data_b    = b_q[7:0];
        OUT_ALU_OP    = op_q;
        OUT_carry_out = (op_q == OP_SUB) || (op_q == OP_CMP);
      end
      S_HIGH: begin
        OUT_data_a = a_q[15:8];
        OUT_data_b = b_q[15:8];
        OUT_ALU_OP = op_q;
        if ((op_q == OP_ADD) || (op_q == OP_SUB)) OUT_carry_out = c_lo_q;
        else if (op_q == OP_CMP)                  OUT_carry_out = ~c_lo_q;
        else                                      OUT_carry_out = 1'b0;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: byte-slice ALU model, directed vector table, random ops
// against a 16-bit reference, round-robin and mid-operation reset sequences.
module tb_alu_arbiter;

  localparam logic [3:0] OP_ADD = 4'hA, OP_SUB = 4'hB, OP_AND = 4'hC,
                         OP_OR  = 4'hD, OP_CMP = 4'hE;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  req;
  logic [3:0]  op0, op1;
  logic [15:0] a0, b0, a1, b1;
  logic [7:0]  alu_s;
  logic        alu_c, alu_z;
  logic [7:0]  data_a, data_b;
  logic [3:0]  alu_op;
  logic        cout;
  logic [1:0]  grant, ack;
  logic [15:0] result;
  logic        carry, zero, neg_ans, less_than, busy;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  alu_arbiter dut (
    .IN_clk(clk), .IN_reset(reset), .IN_req(req),
    .IN_op0(op0), .IN_a0(a0), .IN_b0(b0),
    .IN_op1(op1), .IN_a1(a1), .IN_b1(b1),
    .IN_S(alu_s), .IN_carry_in(alu_c), .IN_zero(alu_z),
    .OUT_data_a(data_a), .OUT_data_b(data_b), .OUT_ALU_OP(alu_op),
    .OUT_carry_out(cout), .OUT_grant(grant), .OUT_ack(ack),
    .OUT_result(result), .OUT_carry(carry), .OUT_zero(zero),
    .OUT_neg_ans(neg_ans), .OUT_less_than(less_than), .OUT_busy(busy)
  );

  // External 8-bit ALU. CMP takes an active-low borrow in and returns borrow out.
  logic [8:0] alu_t;
  always_comb begin
    alu_t = '0;
    case (alu_op)
      OP_ADD:  alu_t = {1'b0, data_a} + {1'b0, data_b} + {8'b0, cout};
      OP_SUB:  alu_t = {1'b0, data_a} + {1'b0, ~data_b} + {8'b0, cout};
      OP_AND:  alu_t = {1'b0, data_a & data_b};
      OP_OR:   alu_t = {1'b0, data_a | data_b};
      OP_CMP:  alu_t = {1'b0, data_a} - {1'b0, data_b} - {8'b0, ~cout};
      default: alu_t = {1'b0, data_a ^ data_b};
    endcase
    alu_s = alu_t[7:0];
    alu_c = alu_t[8];
    alu_z = (alu_t[7:0] == 8'h00);
  end

  typedef struct {
    logic [15:0] res;
    logic        c, z, n, lt;
  } exp_t;

  typedef struct {
    int          port;
    logic [3:0]  op;
    logic [15:0] a, b;
    exp_t        e;
  } vec_t;

  // Whole-word view of each operation; the ALU of unknown opcodes is XOR.
  function automatic exp_t ref_model(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    exp_t r;
    int unsigned ai = a, bi = b, s;
    r.c = 1'b0; r.lt = 1'b0;
    case (op)
      OP_ADD:  begin s = ai + bi; r.c = (s > 32'hFFFF); end
      OP_SUB:  begin s = ai - bi; r.c = (ai >= bi); end
      OP_AND:  s = ai & bi;
      OP_OR:   s = ai | bi;
      OP_CMP:  begin s = ai - bi; r.c = (ai < bi); r.lt = (ai < bi); end
      default: s = ai ^ bi;
    endcase
    r.res = s[15:0];
    r.z   = (r.res == 16'h0);
    r.n   = r.res[15];
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    req   = 2'b00;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic run_op(input int port, input logic [3:0] op, input logic [15:0] a,
                        input logic [15:0] b, input exp_t e);
    int lat;
    logic [1:0] gmask;
    gmask = (port == 0) ? 2'b01 : 2'b10;
    @(negedge clk);
    if (port == 0) begin op0 = op; a0 = a; b0 = b; end
    else           begin op1 = op; a1 = a; b1 = b; end
    req = gmask;
    @(posedge clk);
    @(negedge clk);
    lat = 1;
    chk("low_data", {data_a, data_b, alu_op}, {a[7:0], b[7:0], op});
    chk("low_cin", cout, (op == OP_SUB) || (op == OP_CMP));
    chk("grant", grant, gmask);
    op0 = 4'($urandom); a0 = 16'($urandom); b0 = 16'($urandom);
    op1 = 4'($urandom); a1 = 16'($urandom); b1 = 16'($urandom);
    @(negedge clk);
    lat = 2;
    chk("high_data", {data_a, data_b, alu_op}, {a[15:8], b[15:8], op});
    while (ack == 2'b00 && lat < 8) begin
      @(negedge clk);
      lat++;
    end
    chk("ack_latency", lat, 3);
    chk("ack", ack, gmask);
    chk("result", result, e.res);
    chk("flags", {carry, zero, neg_ans, less_than}, {e.c, e.z, e.n, e.lt});
    req = 2'b00;
    @(negedge clk);
    chk("idle_after_done", {ack, grant, busy, data_a, alu_op}, '0);
    chk("result_hold", result, e.res);
  endtask

  vec_t vecs[10];
  int   ack_cyc, last_cyc;
  logic [1:0] exp_q[$];

  initial begin
    vecs[0] = '{0, OP_ADD, 16'h00FF, 16'h0001, '{16'h0100, 0, 0, 0, 0}};
    vecs[1] = '{1, OP_SUB, 16'h0005, 16'h0007, '{16'hFFFE, 0, 0, 1, 0}};
    vecs[2] = '{0, OP_CMP, 16'h0003, 16'h0009, '{16'hFFFA, 1, 0, 1, 1}};
    vecs[3] = '{0, OP_CMP, 16'h0009, 16'h0003, '{16'h0006, 0, 0, 0, 0}};
    vecs[4] = '{0, OP_AND, 16'hF0F0, 16'h0F0F, '{16'h0000, 0, 1, 0, 0}};
    vecs[5] = '{0, OP_OR,  16'hF0F0, 16'h0F0F, '{16'hFFFF, 0, 0, 1, 0}};
    vecs[6] = '{1, OP_ADD, 16'hFFFF, 16'h0001, '{16'h0000, 1, 1, 0, 0}};
    vecs[7] = '{0, 4'h3,   16'h1234, 16'h00FF, '{16'h12CB, 0, 0, 0, 0}};
    vecs[8] = '{0, OP_SUB, 16'h1234, 16'h1234, '{16'h0000, 1, 1, 0, 0}};
    vecs[9] = '{1, OP_CMP, 16'h0100, 16'h00FF, '{16'h0001, 0, 0, 0, 0}};

    reset = 1'b1; req = 2'b00;
    op0 = '0; a0 = '0; b0 = '0; op1 = '0; a1 = '0; b1 = '0;
    repeat (2) @(negedge clk);
    chk("reset_outputs", {data_a, data_b, alu_op, cout, grant, ack, result,
                          carry, zero, neg_ans, less_than, busy}, '0);
    reset = 1'b0;
    @(negedge clk);
    chk("idle_no_req", {grant, ack, busy}, '0);

    foreach (vecs[i]) run_op(vecs[i].port, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].e);

    for (int i = 0; i < 40; i++) begin
      logic [3:0]  rop;
      logic [15:0] ra, rb;
      rop = ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'(OP_ADD + $urandom_range(0, 4));
      ra  = 16'($urandom);
      rb  = ($urandom_range(0, 7) == 0) ? ra : 16'($urandom);
      run_op($urandom_range(0, 1), rop, ra, rb, ref_model(rop, ra, rb));
    end

    // Both requesters held from reset: grants must alternate starting with 0.
    do_reset();
    op0 = OP_ADD; a0 = 16'h0001; b0 = 16'h0002;
    op1 = OP_OR;  a1 = 16'h00F0; b1 = 16'h000F;
    exp_q = '{2'b01, 2'b10, 2'b01, 2'b10};
    req = 2'b11;
    last_cyc = -1;
    for (ack_cyc = 0; ack_cyc < 40 && exp_q.size() != 0; ack_cyc++) begin
      @(negedge clk);
      if (ack != 2'b00) begin
        logic [1:0] want;
        want = exp_q.pop_front();
        chk("rr_ack", ack, want);
        chk("rr_result", result, (want == 2'b01) ? 16'h0003 : 16'h00FF);
        if (last_cyc >= 0) chk("rr_spacing", ack_cyc - last_cyc, 4);
        last_cyc = ack_cyc;
      end
    end
    chk("rr_all_acks", exp_q.size(), 0);
    req = 2'b00;
    @(negedge clk);
    chk("rr_idle", {ack, grant, busy}, '0);

    // Reset during the high slice aborts with no ack and a cleared result.
    @(negedge clk);
    op1 = OP_SUB; a1 = 16'h5555; b1 = 16'h1111;
    req = 2'b10;
    @(posedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("abort_in_high", {busy, grant}, {1'b1, 2'b10});
    reset = 1'b1;
    req   = 2'b00;
    @(negedge clk);
    chk("abort_outputs", {data_a, data_b, alu_op, cout, grant, ack, result,
                          carry, zero, neg_ans, less_than, busy}, '0);
    reset = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("abort_no_ack", {ack, busy}, '0);
    end
    run_op(1, OP_SUB, 16'h5555, 16'h1111, '{16'h4444, 1, 0, 0, 0});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
